// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL wrapper / syscon side and pll_reset_ctrl.
// Ports: locked, soft_req (to controller); periph_reset, cpu_reset, pll_ok, lock_loss_count (from controller).
interface pll_reset_ctrl_if;
  logic       locked;
  logic       soft_req;
  logic       periph_reset;
  logic       cpu_reset;
  logic       pll_ok;
  logic [7:0] lock_loss_count;

  modport master (
    output locked,
    output soft_req,
    input  periph_reset,
    input  cpu_reset,
    input  pll_ok,
    input  lock_loss_count
  );

  modport slave (
    input  locked,
    input  soft_req,
    output periph_reset,
    output cpu_reset,
    output pll_ok,
    output lock_loss_count
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// Reset sequencer driven by PLL lock: peripherals released first, CPU STAGE_GAP later.
// Ports: clock, reset (async, active-high); io.slave = locked, soft_req in;
//   periph_reset, cpu_reset, pll_ok, lock_loss_count out.
// Optional macro LOCK_LOSS_COUNT_EN builds the saturating lock-loss counter.
module pll_reset_ctrl #(
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int SOFT_HOLD   = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  pll_reset_ctrl_if.slave   io
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    STAGE,
    RUN,
    SOFT
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SOFT_LD = CNT_W'(SOFT_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q;
  logic             locked_s_q;
  logic             periph_q, periph_d;
  logic             cpu_q, cpu_d;
  logic             ok_q, ok_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= io.locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      ok_q     <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s_q) begin
          state_d = STABLE;
          cnt_d   = LOCK_LD;
        end
      end
      STABLE: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = STAGE;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STAGE: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        // lock loss has priority over a coincident soft request
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (io.soft_req) begin
          state_d = SOFT;
          cnt_d   = SOFT_LD;
        end
      end
      SOFT: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = STAGE;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs are registered from the next state, so they change
  // on the same edge as the state and never glitch
  always_comb begin
    periph_d = 1'b1;
    cpu_d    = 1'b1;
    ok_d     = 1'b0;
    if (state_d == STAGE) begin
      periph_d = 1'b0;
    end
    if (state_d == RUN) begin
      periph_d = 1'b0;
      cpu_d    = 1'b0;
      ok_d     = 1'b1;
    end
  end

  assign io.periph_reset = periph_q;
  assign io.cpu_reset    = cpu_q;
  assign io.pll_ok       = ok_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic       prev_q;
  logic [7:0] llc_q;
  logic       fall;

  assign fall = prev_q & ~locked_s_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      llc_q  <= 8'd0;
    end else begin
      prev_q <= locked_s_q;
      if (fall && (state_q != WAIT_LOCK) && (llc_q != 8'hFF)) begin
        llc_q <= llc_q + 8'd1;
      end
    end
  end

  assign io.lock_loss_count = llc_q;
`else
  assign io.lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl (LOCK_CYCLES=8, STAGE_GAP=4, SOFT_HOLD=6).
// Expected output transitions are queued by stimulus and popped by a monitor.
module tb_pll_reset_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pll_reset_ctrl_if bus ();

  pll_reset_ctrl #(
    .LOCK_CYCLES (8),
    .STAGE_GAP   (4),
    .SOFT_HOLD   (6),
    .CNT_W       (16)
  ) dut (
    .clock (clk),
    .reset (rst),
    .io    (bus)
  );

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } llc_t;

  exp_t exp_q[$];
  llc_t llc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_llc = 0;
  logic [2:0] last = 3'b110;

  // {periph_reset, cpu_reset, pll_ok}
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t e;
    llc_t l;
    cur = {bus.periph_reset, bus.cpu_reset, bus.pll_ok};
    if (cur !== last) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val !== cur) begin
          errors++;
          $display("FAIL out_change got cyc=%0d val=%b exp cyc=%0d val=%b",
                   cyc, cur, e.cyc, e.val);
        end
      end
      last = cur;
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_change exp cyc=%0d val=%b got=%b at cyc=%0d",
               e.cyc, e.val, cur, cyc);
    end
    if (llc_q.size() > 0 && llc_q[0].cyc == cyc) begin
      l = llc_q.pop_front();
      checks++;
      if (bus.lock_loss_count !== l.val) begin
        errors++;
        $display("FAIL lock_loss_count cyc=%0d got=%0d exp=%0d",
                 cyc, bus.lock_loss_count, l.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int c, input logic [2:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic llc_event();
`ifdef LOCK_LOSS_COUNT_EN
    if (exp_llc < 255) exp_llc++;
`endif
  endtask

  task automatic check_llc();
    llc_t l;
    l.cyc = cyc;
    l.val = 8'(exp_llc);
    llc_q.push_back(l);
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // locked rises now; first sampling edge is cyc+1
  task automatic relock_full();
    bus.locked = 1'b1;
    push(cyc + 11, 3'b010);
    push(cyc + 15, 3'b001);
    tick(20);
  endtask

  task automatic lose_lock();
    bus.locked = 1'b0;
    push(cyc + 3, 3'b110);
    llc_event();
    tick(6);
  endtask

  initial begin
    int t1;
    int k;
    bus.locked   = 1'b0;
    bus.soft_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_periph", 8'(bus.periph_reset), 8'd1);
    chk("rst_cpu", 8'(bus.cpu_reset), 8'd1);
    chk("rst_ok", 8'(bus.pll_ok), 8'd0);
    chk("rst_llc", bus.lock_loss_count, 8'd0);
    tick(3);
    rst = 1'b0;

    // power-up: locked first sampled at edge 10
    while (cyc < 9) tick(1);
    relock_full();
    check_llc();

    // lock loss in RUN, then full relock
    lose_lock();
    relock_full();
    check_llc();

    // one-cycle glitch four cycles into STABLE
    lose_lock();
    bus.locked = 1'b1;
    tick(6);
    bus.locked = 1'b0;
    tick(1);
    bus.locked = 1'b1;
    llc_event();
    push(cyc + 11, 3'b010);
    push(cyc + 15, 3'b001);
    tick(20);
    check_llc();

    // soft request in RUN
    bus.soft_req = 1'b1;
    push(cyc + 1, 3'b110);
    push(cyc + 7, 3'b010);
    push(cyc + 11, 3'b001);
    tick(1);
    bus.soft_req = 1'b0;
    tick(15);
    check_llc();

    // soft request in STABLE is ignored
    lose_lock();
    bus.locked = 1'b1;
    push(cyc + 11, 3'b010);
    push(cyc + 15, 3'b001);
    tick(5);
    bus.soft_req = 1'b1;
    tick(1);
    bus.soft_req = 1'b0;
    tick(15);

    // soft request coincident with lock loss: no SOFT entry
    bus.locked = 1'b0;
    push(cyc + 3, 3'b110);
    llc_event();
    tick(1);
    bus.locked = 1'b1;
    push(cyc + 11, 3'b010);
    push(cyc + 15, 3'b001);
    tick(1);
    bus.soft_req = 1'b1;
    tick(1);
    bus.soft_req = 1'b0;
    tick(20);
    check_llc();

    // 300 lock-loss events for saturation
    bus.locked = 1'b0;
    push(cyc + 3, 3'b110);
    llc_event();
    tick(1);
    bus.locked = 1'b1;
    t1 = cyc;
    tick(3);
    for (int i = 0; i < 299; i++) begin
      bus.locked = 1'b0;
      llc_event();
      tick(1);
      bus.locked = 1'b1;
      t1 = cyc;
      tick(3);
    end
    push(t1 + 11, 3'b010);
    push(t1 + 15, 3'b001);
    tick(20);
    check_llc();

    // async reset in the middle of STAGE
    lose_lock();
    bus.locked = 1'b1;
    k = cyc;
    push(k + 11, 3'b010);
    tick(12);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_periph", 8'(bus.periph_reset), 8'd1);
    chk("mid_cpu", 8'(bus.cpu_reset), 8'd1);
    chk("mid_ok", 8'(bus.pll_ok), 8'd0);
    chk("mid_llc", bus.lock_loss_count, 8'd0);
    exp_llc = 0;
    push(k + 13, 3'b110);
    tick(2);
    rst = 1'b0;
    push(cyc + 11, 3'b010);
    push(cyc + 15, 3'b001);
    tick(20);
    check_llc();

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && llc_q.size() == 0) break;
      tick(1);
    end
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_out exp cyc=%0d val=%b", exp_q[0].cyc, exp_q[0].val);
      void'(exp_q.pop_front());
    end
    while (llc_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_llc exp cyc=%0d val=%0d", llc_q[0].cyc, llc_q[0].val);
      void'(llc_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
